// File: rtl/enc_pkg.sv
// Shared types and constants for the quadrature encoder decoder.
package enc_pkg;
    localparam int COUNT_W = 16;
    localparam int ERR_W   = 8;

    typedef enum logic {INIT, TRACK} state_t;

    typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR} step_t;

    // Maps {A,B} onto its position in the forward sequence 00,01,11,10.
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] d;
        d = gray_pos(cur) - gray_pos(prev);
        case (d)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_UP;
            2'd3:    return STEP_DN;
            default: return STEP_ERR;
        endcase
    endfunction
endpackage

// File: rtl/enc_quad_decoder_if.sv
// Encoder pins, control pulses and count/status outputs of one encoder slot.
interface enc_quad_decoder_if;
    import enc_pkg::*;

    logic               encA;
    logic               encB;
    logic               clear;
    logic               snapshot;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] snap;
    logic               dir;
    logic [ERR_W-1:0]   err_cnt;
    logic               valid;

    modport master (
        output encA, encB, clear, snapshot,
        input  count, snap, dir, err_cnt, valid
    );

    modport slave (
        input  encA, encB, clear, snapshot,
        output count, snap, dir, err_cnt, valid
    );
endinterface

// File: rtl/enc_glitch_filter.sv
// One encoder channel: 2-FF synchroniser followed by a run-length glitch filter.
// Latency: 2 clk to sync, then FILTER_LEN ticks of a stable level to update filt.
// Backpressure: none; free-running, load forces filt to the current sync value.
module enc_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    input  logic load,
    output logic sync,
    output logic filt
);
    logic       meta;
    logic [3:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            filt <= 1'b0;
            run  <= 4'd0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (load) begin
                filt <= sync;
                run  <= 4'd0;
            end else if (tick) begin
                // The tick that completes the run accepts the new level.
                if (sync != filt) begin
                    if (run == 4'(FILTER_LEN - 1)) begin
                        filt <= sync;
                        run  <= 4'd0;
                    end else begin
                        run <= run + 4'd1;
                    end
                end else begin
                    run <= 4'd0;
                end
            end
        end
    end
endmodule

// File: rtl/enc_quad_decoder.sv
// Quadrature A/B decoder with 16-bit position count, error counter and tear-free snapshot.
// Latency: with PRESCALE=1 an input edge reaches count FILTER_LEN+3 clk later.
// Backpressure: none; clear and snapshot are single-cycle pulses.
module enc_quad_decoder
    import enc_pkg::*;
#(
    parameter int PRESCALE   = 1,
    parameter int FILTER_LEN = 4,
    parameter int INVERT     = 0
) (
    input  logic                clk,
    input  logic                nReset,
    enc_quad_decoder_if.slave   enc
);
    logic [7:0]         pre_cnt;
    logic               tick;
    logic [1:0]         start_cnt;
    logic               start_done;
    state_t             state_q, state_d;
    logic               load;
    logic               sync_a, sync_b, filt_a, filt_b;
    logic [1:0]         prev;
    logic [1:0]         cur;
    step_t              step;
    logic               track_tick;
    logic [COUNT_W-1:0] count_q, snap_q;
    logic [ERR_W-1:0]   err_q;
    logic               dir_q, valid_q;

    assign tick       = (pre_cnt == 8'(PRESCALE - 1));
    assign start_done = (start_cnt == 2'd3);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pre_cnt   <= 8'd0;
            start_cnt <= 2'd0;
            state_q   <= INIT;
        end else begin
            pre_cnt <= tick ? 8'd0 : pre_cnt + 8'd1;
            if (!start_done)
                start_cnt <= start_cnt + 2'd1;
            state_q <= state_d;
        end
    end

    // Wait for the synchronisers to fill before trusting the pins.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            INIT: begin
                if (tick && start_done) begin
                    load    = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK:   state_d = TRACK;
            default: state_d = INIT;
        endcase
    end

    enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .rst_n(nReset), .raw(enc.encA), .tick(tick), .load(load),
        .sync(sync_a), .filt(filt_a)
    );

    enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .rst_n(nReset), .raw(enc.encB), .tick(tick), .load(load),
        .sync(sync_b), .filt(filt_b)
    );

    assign cur        = {filt_a, filt_b};
    assign step       = gray_step(prev, cur);
    assign track_tick = tick && (state_q == TRACK);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            prev    <= 2'b00;
            valid_q <= 1'b0;
            count_q <= '0;
            snap_q  <= '0;
            dir_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            if (load) begin
                prev    <= {sync_a, sync_b};
                valid_q <= 1'b1;
            end else if (track_tick) begin
                prev <= cur;
            end

            // snap takes the pre-update count, so it is unaffected by a same-cycle step or clear.
            if (enc.snapshot)
                snap_q <= count_q;

            if (enc.clear) begin
                count_q <= '0;
                err_q   <= '0;
            end else if (track_tick) begin
                case (step)
                    STEP_UP: begin
                        count_q <= (INVERT != 0) ? count_q - COUNT_W'(1) : count_q + COUNT_W'(1);
                        dir_q   <= (INVERT == 0);
                    end
                    STEP_DN: begin
                        count_q <= (INVERT != 0) ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);
                        dir_q   <= (INVERT != 0);
                    end
                    STEP_ERR: begin
                        if (err_q != '1)
                            err_q <= err_q + ERR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign enc.count   = count_q;
    assign enc.snap    = snap_q;
    assign enc.dir     = dir_q;
    assign enc.err_cnt = err_q;
    assign enc.valid   = valid_q;
endmodule

// File: tb/tb_enc_quad_decoder.sv
// Directed bench for enc_quad_decoder with PRESCALE=1, FILTER_LEN=4, INVERT=0.
module tb_enc_quad_decoder;
    import enc_pkg::*;

    logic       clk = 1'b0;
    logic       nReset;
    int         total = 0;
    int         bad = 0;
    logic [1:0] pos;
    logic [1:0] gtab [4];

    enc_quad_decoder_if bus ();

    enc_quad_decoder #(.PRESCALE(1), .FILTER_LEN(4), .INVERT(0)) dut (
        .clk(clk),
        .nReset(nReset),
        .enc(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance n clocks, landing 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_edge(input bit up);
        pos = up ? pos + 2'd1 : pos - 2'd1;
        {bus.encA, bus.encB} = gtab[pos];
        cyc(8);
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        bus.encA = 1'b1; bus.encB = 1'b1;
        bus.clear = 1'b0; bus.snapshot = 1'b0;
        pos = 2'd2;
        cyc(3);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL rst_count: got %h want 0000", bus.count); end
        total++; if (bus.snap !== 16'h0000) begin bad++; $display("FAIL rst_snap: got %h want 0000", bus.snap); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL rst_dir: got %b want 0", bus.dir); end
        total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err: got %h want 00", bus.err_cnt); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
        nReset = 1'b1;
        for (int i = 0; i < 8 && bus.valid !== 1'b1; i++) cyc(1);
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL valid_up: got %b want 1 within 8 clk", bus.valid); end
        cyc(2);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL init_count: got %h want 0000", bus.count); end
        total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL init_err: got %h want 00", bus.err_cnt); end
    endtask

    task automatic test_fwd_rev();
        for (int i = 0; i < 16; i++) step_edge(1'b1);
        total++; if (bus.count !== 16'd16) begin bad++; $display("FAIL fwd_count: got %h want 0010", bus.count); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL fwd_dir: got %b want 1", bus.dir); end
        for (int i = 0; i < 4; i++) step_edge(1'b0);
        total++; if (bus.count !== 16'd12) begin bad++; $display("FAIL rev_count: got %h want 000c", bus.count); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL rev_dir: got %b want 0", bus.dir); end
    endtask

    task automatic test_wrap();
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL clear_count: got %h want 0000", bus.count); end
        step_edge(1'b0);
        total++; if (bus.count !== 16'hFFFF) begin bad++; $display("FAIL wrap_dn: got %h want ffff", bus.count); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL wrap_dn_dir: got %b want 0", bus.dir); end
        step_edge(1'b1);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL wrap_up: got %h want 0000", bus.count); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL wrap_up_dir: got %b want 1", bus.dir); end
    endtask

    task automatic test_glitch_latency();
        bus.encA = 1'b0; cyc(2); bus.encA = 1'b1; cyc(10);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL glitch_count: got %h want 0000", bus.count); end
        total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL glitch_err: got %h want 00", bus.err_cnt); end
        pos = pos - 2'd1;
        {bus.encA, bus.encB} = gtab[pos];
        cyc(6);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL lat_early: got %h want 0000 at t+6", bus.count); end
        cyc(1);
        total++; if (bus.count !== 16'hFFFF) begin bad++; $display("FAIL lat_edge: got %h want ffff at t+7", bus.count); end
        cyc(1);
        step_edge(1'b1);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 300; i++) begin
            pos = pos ^ 2'd2;
            {bus.encA, bus.encB} = gtab[pos];
            cyc(8);
            if (i == 2) begin
                total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL err_three: got %h want 03", bus.err_cnt); end
            end
        end
        total++; if (bus.err_cnt !== 8'hFF) begin bad++; $display("FAIL err_sat: got %h want ff", bus.err_cnt); end
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL err_count: got %h want 0000", bus.count); end
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL err_clear: got %h want 00", bus.err_cnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 511; i++) step_edge(1'b1);
        total++; if (bus.count !== 16'h01FF) begin bad++; $display("FAIL pre_snap: got %h want 01ff", bus.count); end
        pos = pos + 2'd1;
        {bus.encA, bus.encB} = gtab[pos];
        cyc(6);
        bus.snapshot = 1'b1; cyc(1); bus.snapshot = 1'b0;
        total++; if (bus.snap !== 16'h01FF) begin bad++; $display("FAIL snap_val: got %h want 01ff", bus.snap); end
        total++; if (bus.count !== 16'h0200) begin bad++; $display("FAIL snap_step: got %h want 0200", bus.count); end
        pos = pos + 2'd1;
        {bus.encA, bus.encB} = gtab[pos];
        cyc(6);
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL clr_step: got %h want 0000", bus.count); end
        total++; if (bus.snap !== 16'h01FF) begin bad++; $display("FAIL clr_snap: got %h want 01ff", bus.snap); end
        cyc(8);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL clr_drop: got %h want 0000", bus.count); end
    endtask

    task automatic test_async_reset();
        step_edge(1'b1);
        total++; if (bus.count !== 16'h0001) begin bad++; $display("FAIL pre_rst: got %h want 0001", bus.count); end
        nReset = 1'b0;
        #1;
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL arst_count: got %h want 0000", bus.count); end
        total++; if (bus.snap !== 16'h0000) begin bad++; $display("FAIL arst_snap: got %h want 0000", bus.snap); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL arst_dir: got %b want 0", bus.dir); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", bus.valid); end
        cyc(2);
        nReset = 1'b1;
        for (int i = 0; i < 8 && bus.valid !== 1'b1; i++) cyc(1);
        total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL revalid: got %b want 1 within 8 clk", bus.valid); end
        cyc(8);
        total++; if (bus.count !== 16'h0000) begin bad++; $display("FAIL reinit_count: got %h want 0000", bus.count); end
    endtask

    initial begin
        gtab = '{2'b00, 2'b01, 2'b11, 2'b10};
        test_reset();
        test_fwd_rev();
        test_wrap();
        test_glitch_latency();
        test_errors();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_quad_decoder.md
Name: enc_quad_decoder

Overview:
- Upstream feeder for the I/O register file's encoder slots. Turns one raw A/B quadrature pair from the encoder header into a signed-step 16-bit position count.
- Input path: async pins → 2-FF synchroniser → per-channel glitch filter → 4-state Gray decoder → counter.
- The register file reads the count through a coherent snapshot. The CPU reads the low byte, then the high byte, and the two bytes never tear.

Parameters:
- PRESCALE, 1, sample-tick divider; the filter and decoder advance once every PRESCALE clk cycles (range 1..255).
- FILTER_LEN, 4, consecutive sample ticks a synchronised level must persist before it is accepted (range 1..15).
- INVERT, 0, 1 swaps the count direction.

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- encA  in  1  raw quadrature channel A (asynchronous)
- encB  in  1  raw quadrature channel B (asynchronous)
- clear  in  1  one-cycle pulse; zeroes count and err_cnt
- snapshot  in  1  one-cycle pulse; copies count into snap
- count  out  16  live position count
- snap  out  16  coherent copy of count, for byte-wise reads
- dir  out  1  direction of the last valid step (1 = up)
- err_cnt  out  8  illegal-transition counter, saturating
- valid  out  1  high once the decoder is tracking

Behaviour:
- Interface (already decided): one clock, clk. Reset is nReset, asynchronous and active-low.
- Reset values: count=0, snap=0, dir=0, err_cnt=0, valid=0. Synchroniser, filter counters and prescaler are all 0. FSM = INIT.
- Synchroniser: two flops per channel, running every clk regardless of tick.
- Prescaler: counts 0..PRESCALE-1. tick is asserted on the cycle the counter wraps; PRESCALE=1 gives tick every cycle.
- Filter, per channel, on each tick:
  - if sync ≠ filt, the run counter increments; otherwise it clears;
  - when the run counter reaches FILTER_LEN, filt takes the sync value and the counter clears.
- FSM:
  - INIT: on the first tick at least 3 clk after nReset deasserts, load filt and prev directly from sync, set valid=1, go to TRACK. No count change.
  - TRACK: on each tick, compare the current filt {A,B} with prev, then set prev = filt.
  - TRACK has no exit except reset.
- Decoding in TRACK (forward sequence is 00→01→11→10→00):
  - Forward step: +1, dir=1.
  - Reverse step: −1, dir=0.
  - INVERT=1 swaps +1/−1 and the dir value.
  - Both bits changed: illegal. count and dir unchanged; err_cnt increments, saturating at 255.
  - No change: nothing happens.
- Arithmetic: count is 16-bit modulo. 0xFFFF +1 gives 0x0000; 0x0000 −1 gives 0xFFFF.
- Latency (PRESCALE=1): an input edge stable from cycle t appears on count at cycle t+FILTER_LEN+3.
- Simultaneous events on the same cycle:
  - clear together with a step: clear wins; count=0 and the step is discarded.
  - snapshot together with a step or clear: snap captures the pre-update count.
  - clear with an illegal transition: err_cnt=0.
- snap changes only on snapshot. It is never affected by clear.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously), and the FSM re-enters INIT.

Decomposition:
- Shared package enc_pkg holds:
  - FSM state typedef {INIT, TRACK};
  - Gray-step lookup constants (STEP_NONE, STEP_UP, STEP_DN, STEP_ERR);
  - COUNT_W=16 and ERR_W=8.
- One sub-module, enc_glitch_filter: synchroniser plus run-length filter for one channel, instantiated twice. Decoder, counter and snapshot logic stay in the top module.

Test Plan:
- Reset release with encA=1, encB=1 held → valid=1 within FILTER_LEN+4 clk; count=0, err_cnt=0.
- Four forward quadrature cycles (16 edges), each level held 8 clk → count=16, dir=1. Then 4 reverse edges → count=12, dir=0.
- From count=0, one reverse edge → count=0xFFFF. Then one forward edge → count=0x0000.
- encA pulse 2 clk wide with FILTER_LEN=4 → count and err_cnt unchanged. Edge held 4 ticks → count changes exactly at t+7.
- encA and encB toggled in the same cycle, repeated 300 times → count unchanged, err_cnt=255 (saturated). Then clear → err_cnt=0.
- count=0x01FF, then snapshot and a forward step on the same cycle → snap=0x01FF, count=0x0200. Clear together with a step → count=0x0000, snap stays 0x01FF.
